wb_arbiter_2m: RTL and testbench

Two-master, one-slave Wishbone (classic, single-cycle-ack) arbiter for the SoC peripheral bus.
- m0 is the picosoc iomem-to-Wishbone bridge; m1 is a second requester (debug/DMA engine).
- Grants the shared slave bus (e.g. the buttons/LEDs peripheral at 0x0300_0000) by round-robin and holds each grant for a whole cycle.
- A bus-timeout watchdog prevents a non-responding slave from hanging either master.

---
 rtl/wb_arbiter_2m.sv | 200 ++++++++++++++++++++
 tb/tb_wb_arbiter_2m.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_2m.sv
// Two-master, one-slave Wishbone classic arbiter.
// Round-robin grant held for a whole bus cycle, with a bus-timeout
// watchdog that errors out a stuck transfer and drains the bus.
module wb_arbiter_2m #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            resetn,

  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  output logic [DW-1:0]   m0_dat_o,

  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic [DW-1:0]   m1_dat_o,

  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  input  logic            s_ack_i,
  input  logic [DW-1:0]   s_dat_i,

  output logic            timeout_o
);

  // Watchdog is compiled out entirely when TIMEOUT is zero.
  localparam bit            WdEnable = (TIMEOUT != 0);
  localparam logic [7:0]    WdLast   = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT0  = 2'd1,
    GNT1  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic        r_last;
  logic [7:0]  r_wdCnt;

  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_granted;
  logic        w_wdRun;
  logic        w_expire;
  logic        w_drainCyc;

  assign w_gnt0    = (r_state == GNT0);
  assign w_gnt1    = (r_state == GNT1);
  assign w_granted = w_gnt0 | w_gnt1;

  // A granted strobe that is still waiting for its ack keeps the watchdog running.
  assign w_wdRun  = w_granted & s_stb_o & ~s_ack_i;
  assign w_expire = WdEnable & w_wdRun & (r_wdCnt == WdLast);

  // While draining, the owner of the aborted cycle is the last master granted.
  assign w_drainCyc = r_last ? m1_cyc_i : m0_cyc_i;

  // State register; reset drops the grant at once so the slave bus releases asynchronously.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: round-robin arbitration, grant hold, timeout and drain.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          w_nextState = r_last ? GNT0 : GNT1;
        end else if (m0_cyc_i) begin
          w_nextState = GNT0;
        end else if (m1_cyc_i) begin
          w_nextState = GNT1;
        end
      end
      GNT0: begin
        if (!m0_cyc_i) begin
          w_nextState = IDLE;
        end else if (w_expire) begin
          w_nextState = DRAIN;
        end
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          w_nextState = IDLE;
        end else if (w_expire) begin
          w_nextState = DRAIN;
        end
      end
      DRAIN: begin
        if (!w_drainCyc) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Remember who was granted last so the next tie goes to the other master.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_last <= 1'b1;
    end else if (r_state == IDLE) begin
      if (w_nextState == GNT0) begin
        r_last <= 1'b0;
      end else if (w_nextState == GNT1) begin
        r_last <= 1'b1;
      end
    end
  end

  // Watchdog counter: counts unacknowledged strobe cycles, clears on ack, idle strobe or grant change.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wdCnt <= 8'd0;
    end else if (!WdEnable) begin
      r_wdCnt <= 8'd0;
    end else if (w_wdRun && !w_expire && (w_nextState == r_state)) begin
      r_wdCnt <= r_wdCnt + 8'd1;
    end else begin
      r_wdCnt <= 8'd0;
    end
  end

  // Slave-side mux: the granted master drives the slave; nothing is driven in IDLE or DRAIN.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    case (r_state)
      GNT0: begin
        s_cyc_o = m0_cyc_i;
        s_stb_o = m0_stb_i;
        s_we_o  = m0_we_i;
        s_sel_o = m0_sel_i;
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
      end
      GNT1: begin
        s_cyc_o = m1_cyc_i;
        s_stb_o = m1_stb_i;
        s_we_o  = m1_we_i;
        s_sel_o = m1_sel_i;
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
      end
      default: begin
        s_cyc_o = 1'b0;
      end
    endcase
  end

  // Master-side responses: ack and read data reach only the granted master; late acks in DRAIN are dropped.
  always_comb begin
    m0_ack_o  = 1'b0;
    m0_err_o  = 1'b0;
    m0_dat_o  = '0;
    m1_ack_o  = 1'b0;
    m1_err_o  = 1'b0;
    m1_dat_o  = '0;
    timeout_o = w_expire;
    if (w_gnt0) begin
      m0_ack_o = s_ack_i & m0_stb_i;
      m0_err_o = w_expire;
      m0_dat_o = s_dat_i;
    end else if (w_gnt1) begin
      m1_ack_o = s_ack_i & m1_stb_i;
      m1_err_o = w_expire;
      m1_dat_o = s_dat_i;
    end
  end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed self-checking bench for wb_arbiter_2m, built with TIMEOUT=4.
module tb_wb_arbiter_2m;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [31:0] M0_ADR = 32'h0300_0000;
  localparam logic [31:0] M1_ADR = 32'h0300_0010;

  logic          clk;
  logic          resetn;
  logic          m0_cyc_i, m0_stb_i, m0_we_i;
  logic [3:0]    m0_sel_i;
  logic [31:0]   m0_adr_i, m0_dat_i;
  logic          m0_ack_o, m0_err_o;
  logic [31:0]   m0_dat_o;
  logic          m1_cyc_i, m1_stb_i, m1_we_i;
  logic [3:0]    m1_sel_i;
  logic [31:0]   m1_adr_i, m1_dat_i;
  logic          m1_ack_o, m1_err_o;
  logic [31:0]   m1_dat_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]    s_sel_o;
  logic [31:0]   s_adr_o, s_dat_o;
  logic          s_ack_i;
  logic [31:0]   s_dat_i;
  logic          timeout_o;

  int nChecks;
  int nErrors;

  wb_arbiter_2m #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
    .clk(clk), .resetn(resetn),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_sel_i(m0_sel_i), .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_sel_i(m1_sel_i), .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_dat_o(m1_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
    .timeout_o(timeout_o)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive both masters' handshakes and the slave response, then let outputs settle.
  task automatic applyStimulus(input logic c0, input logic s0, input logic c1, input logic s1,
                               input logic ack, input logic [31:0] rdat);
    m0_cyc_i = c0;
    m0_stb_i = s0;
    m1_cyc_i = c1;
    m1_stb_i = s1;
    s_ack_i  = ack;
    s_dat_i  = rdat;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    assert (observed === expected) else begin
      nErrors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    nChecks  = 0;
    nErrors  = 0;
    resetn   = 1'b0;
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b1;
    m0_sel_i = 4'hF; m0_adr_i = M0_ADR; m0_dat_i = 32'h0000_00A5;
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;
    m1_sel_i = 4'h3; m1_adr_i = M1_ADR; m1_dat_i = 32'h0000_005A;
    s_ack_i  = 1'b0; s_dat_i = 32'h0;

    // Reset state
    #2;
    checkOutput("rst_s_cyc", 32'(s_cyc_o), 32'd0);
    checkOutput("rst_s_stb", 32'(s_stb_o), 32'd0);
    checkOutput("rst_s_adr", s_adr_o, 32'd0);
    checkOutput("rst_m0_ack", 32'(m0_ack_o), 32'd0);
    checkOutput("rst_m1_err", 32'(m1_err_o), 32'd0);
    checkOutput("rst_timeout", 32'(timeout_o), 32'd0);
    #10 resetn = 1'b1;

    // 1: single master write, slave acks on the third strobe cycle
    tick();
    applyStimulus(1, 1, 0, 0, 0, 32'h0);
    checkOutput("t1_arb_cycle", 32'(s_cyc_o), 32'd0);
    tick();
    applyStimulus(1, 1, 0, 0, 0, 32'h0);
    checkOutput("t1_s_cyc", 32'(s_cyc_o), 32'd1);
    checkOutput("t1_s_we", 32'(s_we_o), 32'd1);
    checkOutput("t1_s_adr", s_adr_o, 32'h0300_0000);
    checkOutput("t1_s_dat", s_dat_o, 32'h0000_00A5);
    checkOutput("t1_s_sel", 32'(s_sel_o), 32'hF);
    checkOutput("t1_no_ack1", 32'(m0_ack_o), 32'd0);
    tick();
    applyStimulus(1, 1, 0, 0, 0, 32'h0);
    checkOutput("t1_no_ack2", 32'(m0_ack_o), 32'd0);
    tick();
    applyStimulus(1, 1, 0, 0, 1, 32'h0);
    checkOutput("t1_m0_ack", 32'(m0_ack_o), 32'd1);
    checkOutput("t1_m1_ack", 32'(m1_ack_o), 32'd0);
    checkOutput("t1_m0_err", 32'(m0_err_o), 32'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 32'h0);
    checkOutput("t1_ack_once", 32'(m0_ack_o), 32'd0);
    checkOutput("t1_cyc_drop", 32'(s_cyc_o), 32'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 32'h0);

    // 2: tie after reset goes to m0, then m1 after one dead cycle
    resetn = 1'b0;
    #1 resetn = 1'b1;
    m0_we_i = 1'b0;
    applyStimulus(1, 1, 1, 1, 0, 32'h0);
    checkOutput("t2_idle", 32'(s_cyc_o), 32'd0);
    tick();
    applyStimulus(1, 1, 1, 1, 1, 32'h11);
    checkOutput("t2_tie_m0", s_adr_o, M0_ADR);
    checkOutput("t2_m0_ack", 32'(m0_ack_o), 32'd1);
    checkOutput("t2_m1_ack", 32'(m1_ack_o), 32'd0);
    checkOutput("t2_m0_dat", m0_dat_o, 32'h11);
    checkOutput("t2_m1_dat", m1_dat_o, 32'h0);
    tick();
    applyStimulus(0, 0, 1, 1, 0, 32'h0);
    checkOutput("t2_m0_drop", 32'(s_cyc_o), 32'd0);
    tick();
    applyStimulus(0, 0, 1, 1, 0, 32'h0);
    checkOutput("t2_dead_cycle", 32'(s_cyc_o), 32'd0);
    tick();
    applyStimulus(0, 0, 1, 1, 1, 32'h22);
    checkOutput("t2_gnt1_cyc", 32'(s_cyc_o), 32'd1);
    checkOutput("t2_gnt1_adr", s_adr_o, M1_ADR);
    checkOutput("t2_m1_ack", 32'(m1_ack_o), 32'd1);
    checkOutput("t2_m1_dat", m1_dat_o, 32'h22);
    checkOutput("t2_m0_ack_off", 32'(m0_ack_o), 32'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 32'h0);
    tick();
    applyStimulus(1, 1, 0, 0, 0, 32'h0);
    tick();
    applyStimulus(1, 1, 0, 0, 1, 32'h0);
    checkOutput("t2_m0_solo_ack", 32'(m0_ack_o), 32'd1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 32'h0);
    tick();
    applyStimulus(1, 1, 1, 1, 0, 32'h0);
    tick();
    applyStimulus(1, 1, 1, 1, 0, 32'h0);
    checkOutput("t2_tie_m1", s_adr_o, M1_ADR);
    applyStimulus(1, 1, 1, 1, 1, 32'h0);
    checkOutput("t2_tie_m1_ack", 32'(m1_ack_o), 32'd1);
    checkOutput("t2_tie_m0_wait", 32'(m0_ack_o), 32'd0);
    tick();
    applyStimulus(1, 1, 0, 0, 0, 32'h0);
    tick();

    // 3: m0 holds grant through three back-to-back reads while m1 waits
    applyStimulus(1, 1, 1, 1, 0, 32'h0);
    tick();
    applyStimulus(1, 1, 1, 1, 0, 32'h0);
    checkOutput("t3_gnt_m0", s_adr_o, M0_ADR);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1, 1, 1, 1, 1, 32'(i));
      checkOutput("t3_m0_ack", 32'(m0_ack_o), 32'd1);
      checkOutput("t3_m0_dat", m0_dat_o, 32'(i));
      checkOutput("t3_m1_ack", 32'(m1_ack_o), 32'd0);
      checkOutput("t3_m1_dat", m1_dat_o, 32'h0);
      tick();
    end
    applyStimulus(0, 0, 1, 1, 0, 32'h0);
    checkOutput("t3_m0_drop", 32'(s_cyc_o), 32'd0);
    tick();
    applyStimulus(0, 0, 1, 1, 0, 32'h0);
    checkOutput("t3_dead_cycle", 32'(s_cyc_o), 32'd0);
    tick();
    applyStimulus(0, 0, 1, 1, 1, 32'h0);
    checkOutput("t3_gnt_m1", s_adr_o, M1_ADR);
    checkOutput("t3_m1_ack", 32'(m1_ack_o), 32'd1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 32'h0);
    tick();

    // 4: m1 never acked; error on the 4th strobe cycle, then drain
    applyStimulus(0, 0, 1, 1, 0, 32'h0);
    tick();
    applyStimulus(0, 0, 1, 1, 0, 32'h0);
    checkOutput("t4_err_early1", 32'(m1_err_o), 32'd0);
    tick();
    applyStimulus(0, 0, 1, 1, 0, 32'h0);
    tick();
    applyStimulus(0, 0, 1, 1, 0, 32'h0);
    checkOutput("t4_to_early3", 32'(timeout_o), 32'd0);
    tick();
    applyStimulus(1, 1, 1, 1, 0, 32'h0);
    checkOutput("t4_m1_err", 32'(m1_err_o), 32'd1);
    checkOutput("t4_timeout", 32'(timeout_o), 32'd1);
    checkOutput("t4_m1_ack", 32'(m1_ack_o), 32'd0);
    checkOutput("t4_m0_err", 32'(m0_err_o), 32'd0);
    tick();
    applyStimulus(1, 1, 1, 1, 1, 32'h0);
    checkOutput("t4_drain_cyc", 32'(s_cyc_o), 32'd0);
    checkOutput("t4_drain_stb", 32'(s_stb_o), 32'd0);
    checkOutput("t4_late_ack", 32'(m1_ack_o), 32'd0);
    checkOutput("t4_err_pulse", 32'(m1_err_o), 32'd0);
    checkOutput("t4_to_pulse", 32'(timeout_o), 32'd0);
    checkOutput("t4_m0_ack", 32'(m0_ack_o), 32'd0);
    tick();
    applyStimulus(1, 1, 1, 1, 0, 32'h0);
    checkOutput("t4_m0_blocked", 32'(s_cyc_o), 32'd0);
    applyStimulus(1, 1, 0, 0, 0, 32'h0);
    tick();
    applyStimulus(1, 1, 0, 0, 0, 32'h0);
    checkOutput("t4_idle", 32'(s_cyc_o), 32'd0);
    tick();
    applyStimulus(1, 1, 0, 0, 1, 32'h0);
    checkOutput("t4_gnt_m0", s_adr_o, M0_ADR);
    checkOutput("t4_m0_ack2", 32'(m0_ack_o), 32'd1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 32'h0);
    tick();

    // 5: ack on the expiry cycle wins
    applyStimulus(0, 0, 1, 1, 0, 32'h0);
    tick();
    tick();
    tick();
    tick();
    applyStimulus(0, 0, 1, 1, 1, 32'h33);
    checkOutput("t5_m1_ack", 32'(m1_ack_o), 32'd1);
    checkOutput("t5_m1_err", 32'(m1_err_o), 32'd0);
    checkOutput("t5_timeout", 32'(timeout_o), 32'd0);
    checkOutput("t5_m1_dat", m1_dat_o, 32'h33);
    tick();
    applyStimulus(0, 0, 1, 1, 0, 32'h0);
    checkOutput("t5_no_drain", 32'(s_cyc_o), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 32'h0);
    tick();

    // 6: asynchronous reset in the middle of a GNT0 cycle
    applyStimulus(1, 1, 0, 0, 0, 32'h0);
    tick();
    applyStimulus(1, 1, 0, 0, 0, 32'h0);
    checkOutput("t6_gnt0", 32'(s_cyc_o), 32'd1);
    #1 resetn = 1'b0;
    #1;
    checkOutput("t6_async_cyc", 32'(s_cyc_o), 32'd0);
    checkOutput("t6_async_stb", 32'(s_stb_o), 32'd0);
    #2 resetn = 1'b1;
    applyStimulus(1, 1, 1, 1, 0, 32'h0);
    checkOutput("t6_idle", 32'(s_cyc_o), 32'd0);
    tick();
    applyStimulus(1, 1, 1, 1, 0, 32'h0);
    checkOutput("t6_tie_m0", s_adr_o, M0_ADR);
    checkOutput("t6_tie_cyc", 32'(s_cyc_o), 32'd1);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
